// File: rtl/ahb_req_arbiter_pkg.sv
// Shared AHB-Lite encodings, FSM state type and request legality helper
// for the requester-to-AHB arbiter.
package ahb_req_arbiter_pkg;

   localparam logic [1:0] HTRANS_IDLE = 2'b00;
   localparam logic [1:0] HTRANS_BUSY = 2'b01;
   localparam logic [1:0] HTRANS_NSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ  = 2'b11;

   localparam logic [2:0] HSIZE_8  = 3'b000;
   localparam logic [2:0] HSIZE_16 = 3'b001;
   localparam logic [2:0] HSIZE_32 = 3'b010;

   localparam logic [2:0] HBURST_SINGLE   = 3'b000;
   localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      DATA,
      LERR
   } ahb_state_t;

   // Sizes wider than a word, or addresses not aligned to the size, never reach the bus.
   function automatic logic req_is_illegal(input logic [2:0] size, input logic [1:0] addr_lo);
      logic bad;
      bad = 1'b0;
      if (size > HSIZE_32)
         bad = 1'b1;
      else if ((size == HSIZE_16) && addr_lo[0])
         bad = 1'b1;
      else if ((size == HSIZE_32) && (addr_lo != 2'b00))
         bad = 1'b1;
      return bad;
   endfunction

endpackage

// File: rtl/ahb_req_arbiter_if.sv
// Requester-side request/response bundle plus the AHB-Lite master pins.
// The master modport is the arbiter's view; slave is the environment's view.
interface ahb_req_arbiter_if #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32
);
   logic [NUM_REQ-1:0]        req_valid_i;
   logic [NUM_REQ-1:0]        req_ready_o;
   logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
   logic [NUM_REQ-1:0]        req_write_i;
   logic [NUM_REQ*3-1:0]      req_size_i;
   logic [NUM_REQ*DATA_W-1:0] req_wdata_i;
   logic [NUM_REQ-1:0]        rsp_valid_o;
   logic [DATA_W-1:0]         rsp_rdata_o;
   logic                      rsp_err_o;

   logic [ADDR_W-1:0]         ahb_haddr_o;
   logic                      ahb_hwrite_o;
   logic [2:0]                ahb_hsize_o;
   logic [2:0]                ahb_hburst_o;
   logic [3:0]                ahb_hprot_o;
   logic [1:0]                ahb_htrans_o;
   logic                      ahb_hmastlock_o;
   logic [DATA_W-1:0]         ahb_hwdata_o;
   logic                      ahb_hready_i;
   logic                      ahb_hresp_i;
   logic [DATA_W-1:0]         ahb_hrdata_i;

   modport master (
      input  req_valid_i, req_addr_i, req_write_i, req_size_i, req_wdata_i,
      output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
      output ahb_haddr_o, ahb_hwrite_o, ahb_hsize_o, ahb_hburst_o, ahb_hprot_o,
      output ahb_htrans_o, ahb_hmastlock_o, ahb_hwdata_o,
      input  ahb_hready_i, ahb_hresp_i, ahb_hrdata_i
   );

   modport slave (
      output req_valid_i, req_addr_i, req_write_i, req_size_i, req_wdata_i,
      input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
      input  ahb_haddr_o, ahb_hwrite_o, ahb_hsize_o, ahb_hburst_o, ahb_hprot_o,
      input  ahb_htrans_o, ahb_hmastlock_o, ahb_hwdata_o,
      output ahb_hready_i, ahb_hresp_i, ahb_hrdata_i
   );
endinterface

// File: rtl/ahb_req_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first pending request strictly after
// the last grant, wrapping modulo NUM_REQ.
module ahb_req_arbiter_rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_last_grant,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IDX_W-1:0]   o_grant_idx,
   output logic               o_grant_valid
);

   logic [IDX_W-1:0] w_cand;

   always_comb begin
      o_grant       = '0;
      o_grant_idx   = '0;
      o_grant_valid = 1'b0;
      w_cand        = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_cand = IDX_W'((int'(i_last_grant) + k) % NUM_REQ);
         if (!o_grant_valid && i_req[w_cand]) begin
            o_grant_valid   = 1'b1;
            o_grant_idx     = w_cand;
            o_grant[w_cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ahb_req_arbiter.sv
// Shares one AHB-Lite master port between NUM_REQ requesters, running one
// single transfer at a time and returning data/error to the granted requester.
module ahb_req_arbiter
   import ahb_req_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32
) (
   input logic               clk,
   input logic               resetn,
   ahb_req_arbiter_if.master bus
);

   localparam int IDX_W = $clog2(NUM_REQ);

   ahb_state_t          r_state;
   logic [IDX_W-1:0]    r_last_grant;
   logic [NUM_REQ-1:0]  r_gnt_onehot;
   logic [DATA_W-1:0]   r_wdata;
   logic [ADDR_W-1:0]   r_haddr;
   logic                r_hwrite;
   logic [2:0]          r_hsize;
   logic [1:0]          r_htrans;
   logic [DATA_W-1:0]   r_hwdata;
   logic [NUM_REQ-1:0]  r_rsp_valid;
   logic [DATA_W-1:0]   r_rsp_rdata;
   logic                r_rsp_err;

   logic [NUM_REQ-1:0]  w_grant;
   logic [IDX_W-1:0]    w_grant_idx;
   logic                w_grant_valid;
   logic [ADDR_W-1:0]   w_addr  [NUM_REQ];
   logic [2:0]          w_size  [NUM_REQ];
   logic [DATA_W-1:0]   w_wdata [NUM_REQ];
   logic [ADDR_W-1:0]   w_sel_addr;
   logic [2:0]          w_sel_size;
   logic [DATA_W-1:0]   w_sel_wdata;
   logic                w_sel_write;
   logic                w_illegal;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_addr[gi]  = bus.req_addr_i[gi*ADDR_W +: ADDR_W];
      assign w_size[gi]  = bus.req_size_i[gi*3 +: 3];
      assign w_wdata[gi] = bus.req_wdata_i[gi*DATA_W +: DATA_W];
   end

   ahb_req_arbiter_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_arbiter (
      .i_req         (bus.req_valid_i),
      .i_last_grant  (r_last_grant),
      .o_grant       (w_grant),
      .o_grant_idx   (w_grant_idx),
      .o_grant_valid (w_grant_valid)
   );

   assign w_sel_addr  = w_addr[w_grant_idx];
   assign w_sel_size  = w_size[w_grant_idx];
   assign w_sel_wdata = w_wdata[w_grant_idx];
   assign w_sel_write = bus.req_write_i[w_grant_idx];
   assign w_illegal   = req_is_illegal(w_sel_size, w_sel_addr[1:0]);

   // Requests are only ever accepted from IDLE; everywhere else they are ignored.
   assign bus.req_ready_o = (r_state == IDLE) ? w_grant : '0;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state      <= IDLE;
         r_last_grant <= IDX_W'(NUM_REQ - 1);
         r_gnt_onehot <= '0;
         r_wdata      <= '0;
         r_haddr      <= '0;
         r_hwrite     <= 1'b0;
         r_hsize      <= '0;
         r_htrans     <= HTRANS_IDLE;
         r_hwdata     <= '0;
         r_rsp_valid  <= '0;
         r_rsp_rdata  <= '0;
         r_rsp_err    <= 1'b0;
      end else begin
         r_rsp_valid <= '0;
         case (r_state)
            IDLE: begin
               if (w_grant_valid) begin
                  r_last_grant <= w_grant_idx;
                  r_gnt_onehot <= w_grant;
                  // Illegal requests answer during the LERR cycle without touching the bus.
                  if (w_illegal) begin
                     r_state     <= LERR;
                     r_rsp_valid <= w_grant;
                     r_rsp_err   <= 1'b1;
                     r_rsp_rdata <= '0;
                  end else begin
                     r_state  <= ADDR;
                     r_htrans <= HTRANS_NSEQ;
                     r_haddr  <= w_sel_addr;
                     r_hwrite <= w_sel_write;
                     r_hsize  <= w_sel_size;
                     r_wdata  <= w_sel_wdata;
                  end
               end
            end
            ADDR: begin
               if (bus.ahb_hready_i) begin
                  r_state  <= DATA;
                  r_htrans <= HTRANS_IDLE;
                  if (r_hwrite)
                     r_hwdata <= r_wdata;
               end
            end
            DATA: begin
               if (bus.ahb_hready_i) begin
                  r_state     <= IDLE;
                  r_rsp_valid <= r_gnt_onehot;
                  r_rsp_rdata <= r_hwrite ? '0 : bus.ahb_hrdata_i;
                  r_rsp_err   <= bus.ahb_hresp_i;
               end
            end
            LERR: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.ahb_haddr_o     = r_haddr;
   assign bus.ahb_hwrite_o    = r_hwrite;
   assign bus.ahb_hsize_o     = r_hsize;
   assign bus.ahb_htrans_o    = r_htrans;
   assign bus.ahb_hwdata_o    = r_hwdata;
   assign bus.ahb_hburst_o    = HBURST_SINGLE;
   assign bus.ahb_hprot_o     = HPROT_DATA_PRIV;
   assign bus.ahb_hmastlock_o = 1'b0;
   assign bus.rsp_valid_o     = r_rsp_valid;
   assign bus.rsp_rdata_o     = r_rsp_rdata;
   assign bus.rsp_err_o       = r_rsp_err;

endmodule
